// File: rtl/cast_pkg.sv
// Shared port indices and arbitration helpers for the cast VC buffered router.
package cast_pkg;

    localparam int P_LOCAL = 0;
    localparam int P_WEST  = 1;
    localparam int P_EAST  = 2;
    localparam int P_NORTH = 3;
    localparam int P_SOUTH = 4;

    // Helpers work on a fixed-width vector; callers zero-extend narrower masks.
    localparam int MAX_REQ = 64;

    function automatic int unsigned onehot2idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // First set bit of mask at or after ptr, wrapping within the lowest n bits.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] mask,
                                                   input int unsigned       ptr,
                                                   input int unsigned       n);
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int unsigned        idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (!found && mask[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cast_vc_fifo.sv
// Per-(port,VC) flit FIFO; pointers carry one extra wrap bit to tell full from empty.
module cast_vc_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cast_vc_buffered_router.sv
// Buffered multicast mesh router: per-(port,VC) FIFOs feed per-output round-robin
// register stages; a multicast head leaves each branch independently before popping.
module cast_vc_buffered_router
    import cast_pkg::*;
#(
    parameter int PN    = 5,
    parameter int VN    = 2,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter bit [PN-1:0][VN-1:0][PN-1:0] RT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PN*VN-1:0] vc_i,
    input  logic [PN*DW-1:0] data_i,
    input  logic [PN-1:0]    valid_i,
    output logic [PN-1:0]    ready_o,
    output logic [PN*VN-1:0] vc_o,
    output logic [PN*DW-1:0] data_o,
    output logic [PN-1:0]    valid_o,
    input  logic [PN-1:0]    ready_i,
    output logic             err_o
);
    localparam int NR = PN * VN;
    localparam int PW = (NR > 1) ? $clog2(NR) : 1;

    logic [NR-1:0]          fifo_push;
    logic [NR-1:0]          fifo_pop;
    logic [NR-1:0]          fifo_full;
    logic [NR-1:0]          fifo_empty;
    logic [DW-1:0]          head_data [NR];
    logic [PN-1:0]          bad_vc;

    logic [NR-1:0][PN-1:0]  sent_q;
    logic [NR-1:0][PN-1:0]  sent_d;
    logic [NR-1:0][PN-1:0]  served;
    logic [NR-1:0][PN-1:0]  grant_by_req;
    logic [PN-1:0][NR-1:0]  req;
    logic [PN-1:0][NR-1:0]  grant;
    logic [PN-1:0]          load;
    logic [PN-1:0][PW-1:0]  rr_ptr;
    logic [PN-1:0][PW-1:0]  next_ptr;
    logic [PN-1:0][DW-1:0]  win_data;
    logic [PN-1:0][VN-1:0]  win_vc;
    logic [PN-1:0][DW-1:0]  data_q;
    logic [PN-1:0][VN-1:0]  vc_q;
    logic [PN-1:0]          valid_q;
    logic                   err_q;

    // A non-one-hot tag is always accepted so the flit can be dropped.
    for (genvar p = 0; p < PN; p++) begin : g_in
        logic [VN-1:0] vc;
        logic          vc_ok;
        assign vc                    = vc_i[p*VN +: VN];
        assign vc_ok                 = $onehot(vc);
        assign bad_vc[p]             = valid_i[p] && !vc_ok;
        assign ready_o[p]            = !vc_ok || !(|(vc & fifo_full[p*VN +: VN]));
        assign fifo_push[p*VN +: VN] = (valid_i[p] && vc_ok) ? (vc & ~fifo_full[p*VN +: VN]) : '0;
    end

    for (genvar r = 0; r < NR; r++) begin : g_fifo
        cast_vc_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[r]),
            .pop   (fifo_pop[r]),
            .din   (data_i[(r/VN)*DW +: DW]),
            .dout  (head_data[r]),
            .full  (fifo_full[r]),
            .empty (fifo_empty[r])
        );
    end

    always_comb begin
        req = '0;
        for (int o = 0; o < PN; o++) begin
            for (int r = 0; r < NR; r++) begin
                req[o][r] = !fifo_empty[r] && RT[r/VN][r%VN][o] && !sent_q[r][o];
            end
        end
    end

    always_comb begin
        int unsigned widx;
        widx         = 0;
        load         = '0;
        grant        = '0;
        next_ptr     = rr_ptr;
        win_data     = '0;
        win_vc       = '0;
        grant_by_req = '0;
        for (int o = 0; o < PN; o++) begin
            load[o] = !valid_q[o] || ready_i[o];
            if (load[o]) begin
                grant[o] = NR'(rr_pick(MAX_REQ'(req[o]), 32'(rr_ptr[o]), NR));
            end
            widx        = onehot2idx(MAX_REQ'(grant[o]));
            next_ptr[o] = (widx + 1 >= NR) ? '0 : PW'(widx + 1);
            for (int r = 0; r < NR; r++) begin
                if (grant[o][r]) begin
                    win_data[o]        = win_data[o] | head_data[r];
                    win_vc[o][r%VN]    = 1'b1;
                    grant_by_req[r][o] = 1'b1;
                end
            end
        end
    end

    // The head pops once every routed branch has been granted, now or earlier.
    always_comb begin
        fifo_pop = '0;
        sent_d   = sent_q;
        served   = '0;
        for (int r = 0; r < NR; r++) begin
            served[r] = sent_q[r] | grant_by_req[r];
            if (!fifo_empty[r] && (served[r] == RT[r/VN][r%VN])) begin
                fifo_pop[r] = 1'b1;
                sent_d[r]   = '0;
            end else begin
                sent_d[r]   = served[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_q  <= '0;
            rr_ptr  <= '0;
            valid_q <= '0;
            data_q  <= '0;
            vc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            sent_q <= sent_d;
            if (|bad_vc) err_q <= 1'b1;
            for (int o = 0; o < PN; o++) begin
                if (load[o]) begin
                    if (|grant[o]) begin
                        valid_q[o] <= 1'b1;
                        data_q[o]  <= win_data[o];
                        vc_q[o]    <= win_vc[o];
                        rr_ptr[o]  <= next_ptr[o];
                    end else begin
                        valid_q[o] <= 1'b0;
                    end
                end
            end
        end
    end

    assign data_o  = data_q;
    assign vc_o    = vc_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule
